shift_add_multiplier: RTL

Parametrised sequential multiplier that succeeds the repeated-add multiplier for the readout datapath.
- Operands enter through a valid/ready handshake and the result leaves through one.
- Signed or unsigned mode is selected per operation.
- Multiplier bits are consumed BITS_PER_CYCLE at a time (radix 2^K shift-add), with early termination once the remaining multiplier bits are zero.
- A cycle-count output reports latency, for characterising readout timing.

---
 rtl/shift_add_mult_pkg.sv | 48 ++++
 rtl/shift_add_step.sv | 25 ++
 rtl/shift_add_multiplier.sv | 128 ++++++++++++
 3 files changed

// File: rtl/shift_add_mult_pkg.sv
// Shared types and helpers for the shift-add multiplier: FSM states,
// operand magnitude, bit length and step-count arithmetic.
package shift_add_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Widest operand the helper functions handle.
  localparam int unsigned MAX_W = 64;

  localparam int unsigned DEF_WIDTH_IN       = 8;
  localparam int unsigned DEF_BITS_PER_CYCLE = 2;
  localparam int unsigned STEPS_MAX =
    (DEF_WIDTH_IN + DEF_BITS_PER_CYCLE - 1) / DEF_BITS_PER_CYCLE;

  // Worst-case RUN cycles for a w-bit multiplier retired k bits at a time.
  function automatic int unsigned steps_for(input int unsigned w, input int unsigned k);
    return (w + k - 1) / k;
  endfunction

  // Magnitude of the low w bits of x; negated only when sgn is set and the sign bit is 1.
  function automatic logic [MAX_W-1:0] magnitude(input logic [MAX_W-1:0] x,
                                                 input int unsigned w,
                                                 input logic sgn);
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] m;
    mask = (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - MAX_W'(1));
    m    = x & mask;
    if (sgn && (w > 0) && m[w-1]) begin
      m = (~m + MAX_W'(1)) & mask;
    end
    return m;
  endfunction

  // Position of the highest set bit plus one; zero for a zero input.
  function automatic int unsigned bitlen(input logic [MAX_W-1:0] x);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < MAX_W; i++) begin
      if (x[i]) n = i + 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/shift_add_step.sv
// One radix-2^K shift-add step: adds the multiplicand times a K-bit digit into the accumulator.
module shift_add_step
  import shift_add_mult_pkg::*;
#(
  parameter int unsigned ACC_W = 16,
  parameter int unsigned K     = 2
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [ACC_W-1:0] mag_a_shifted,
  input  logic [K-1:0]     digit,
  output logic [ACC_W-1:0] acc_next
);

  logic [ACC_W-1:0] partial;

  // Digit times multiplicand as a sum of shifted copies; overflow past ACC_W is dropped.
  always_comb begin
    partial = '0;
    for (int unsigned i = 0; i < K; i++) begin
      if (digit[i]) partial = partial + (mag_a_shifted << i);
    end
    acc_next = acc + partial;
  end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential signed/unsigned shift-add multiplier with valid/ready handshakes,
// early termination on an exhausted multiplier and a per-product cycle count.
module shift_add_multiplier
  import shift_add_mult_pkg::*;
#(
  parameter int unsigned WIDTH_IN       = 8,
  parameter int unsigned WIDTH_OUT      = 2 * WIDTH_IN,
  parameter int unsigned BITS_PER_CYCLE = 2,
  parameter int unsigned CNT_W          = $clog2(WIDTH_IN + 1)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 is_signed,
  input  logic [WIDTH_IN-1:0]  multiplicand,
  input  logic [WIDTH_IN-1:0]  multiplier,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH_OUT-1:0] product,
  output logic [CNT_W-1:0]     cycles
);

  localparam int unsigned K     = BITS_PER_CYCLE;
  localparam int unsigned ACC_W = 2 * WIDTH_IN;
  localparam int unsigned STEPS = steps_for(WIDTH_IN, K);
  // Multiplier register padded to whole digits so the last step sees zero-extended bits.
  localparam int unsigned MB_W  = STEPS * K;
  localparam int unsigned PW    = (WIDTH_OUT > ACC_W) ? WIDTH_OUT : ACC_W;

  state_t state, state_n;
  logic   accept_c, finish_c, release_c;

  logic [ACC_W-1:0] acc, acc_next, mag_a_sh;
  logic [MB_W-1:0]  mag_b, mag_b_shifted;
  logic             neg;
  logic [CNT_W-1:0] cnt;
  logic [PW-1:0]    acc_wide, result_wide;

  shift_add_step #(
    .ACC_W (ACC_W),
    .K     (K)
  ) u_step (
    .acc           (acc),
    .mag_a_shifted (mag_a_sh),
    .digit         (mag_b[K-1:0]),
    .acc_next      (acc_next)
  );

  assign mag_b_shifted = mag_b >> K;
  assign acc_wide      = PW'(acc_next);
  // A zero accumulator negates to zero, so a zero multiplier never yields -0.
  assign result_wide   = neg ? (~acc_wide + PW'(1)) : acc_wide;

  // State register
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_n;
  end

  // Next state and control strobes
  always_comb begin
    state_n   = state;
    accept_c  = 1'b0;
    finish_c  = 1'b0;
    release_c = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          accept_c = 1'b1;
          state_n  = RUN;
        end
      end
      RUN: begin
        if (mag_b_shifted == '0) begin
          finish_c = 1'b1;
          state_n  = DONE;
        end
      end
      DONE: begin
        if (out_valid && out_ready) begin
          release_c = 1'b1;
          state_n   = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Operand, accumulator and handshake registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      product   <= '0;
      cycles    <= '0;
      acc       <= '0;
      mag_a_sh  <= '0;
      mag_b     <= '0;
      neg       <= 1'b0;
      cnt       <= '0;
    end else begin
      in_ready <= (state_n == IDLE);

      if (accept_c) begin
        mag_a_sh <= ACC_W'(magnitude(MAX_W'(multiplicand), WIDTH_IN, is_signed));
        mag_b    <= MB_W'(magnitude(MAX_W'(multiplier), WIDTH_IN, is_signed));
        neg      <= is_signed & (multiplicand[WIDTH_IN-1] ^ multiplier[WIDTH_IN-1]);
        acc      <= '0;
        cnt      <= '0;
      end else if (state == RUN) begin
        acc      <= acc_next;
        mag_a_sh <= mag_a_sh << K;
        mag_b    <= mag_b_shifted;
        cnt      <= cnt + CNT_W'(1);
      end

      if (finish_c) begin
        product   <= WIDTH_OUT'(result_wide);
        cycles    <= cnt + CNT_W'(1);
        out_valid <= 1'b1;
      end else if (release_c) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
